// File: rtl/mult_control_if.sv
// -----------------------------------------------------------------------------
// mult_control_if
// Strobe/handshake bundle between the multiplier control unit and the
// accumulator/shift register (ACC) plus the requesting agent.
//
//   St    start request (level)            -> control
//   M     multiplier LSB, ACC bit 0         -> control
//   Abort early termination (only when MULT_CONTROL_ABORT_EN is defined)
//   Load  ACC load strobe                   <- control
//   Sh    ACC shift-right strobe            <- control
//   Ad    ACC add strobe                    <- control
//   Done  product valid, held for handshake <- control
//   Busy  operation in progress             <- control
//
// Modports: slave = the control unit, master = requester/ACC side.
// Optional feature macro: MULT_CONTROL_ABORT_EN (adds Abort).
// -----------------------------------------------------------------------------
interface mult_control_if;
    logic St;
    logic M;
    logic Load;
    logic Sh;
    logic Ad;
    logic Done;
    logic Busy;
`ifdef MULT_CONTROL_ABORT_EN
    logic Abort;

    modport slave  (input  St, M, Abort, output Load, Sh, Ad, Done, Busy);
    modport master (output St, M, Abort, input  Load, Sh, Ad, Done, Busy);
`else
    modport slave  (input  St, M, output Load, Sh, Ad, Done, Busy);
    modport master (output St, M, input  Load, Sh, Ad, Done, Busy);
`endif
endinterface

// File: rtl/mult_control.sv
// -----------------------------------------------------------------------------
// mult_control
// Control unit for a WIDTH-bit shift-and-add multiplier. Generates the ACC
// Load/Sh/Ad strobes from a start request and the current multiplier LSB (M),
// counts WIDTH iterations and signals completion with a Done/St handshake.
//
// Ports:
//   Clk    rising-edge clock
//   Rst_n  asynchronous active-low reset (forces IDLE, outputs 0 at once)
//   ctl    mult_control_if.slave: St, M, [Abort] in; Load, Sh, Ad, Done, Busy out
//
// Strobes are decoded combinationally from the state register (plus M in RUN)
// so the ACC acts on the edge that closes the strobe cycle. Because every
// output is a pure decode of the asynchronously reset state, reset drives all
// outputs low without waiting for a clock edge.
//
// Optional feature macro: MULT_CONTROL_ABORT_EN. When defined, ctl.Abort high
// in LOAD/RUN/SHIFT returns the block to IDLE (cnt cleared, no Done).
// -----------------------------------------------------------------------------
module mult_control #(
    parameter int WIDTH = 32
) (
    input  logic                Clk,
    input  logic                Rst_n,
    mult_control_if.slave       ctl
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        RUN   = 3'd2,
        SHIFT = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t             state_r;
    state_t             state_next_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   cnt_next_s;
    logic               last_iter_s;
    logic               abort_s;
    logic               load_s;
    logic               sh_s;
    logic               ad_s;
    logic               done_s;
    logic               busy_s;

`ifdef MULT_CONTROL_ABORT_EN
    assign abort_s = ctl.Abort;
`else
    assign abort_s = 1'b0;
`endif

    // Final iteration: the shift closing this cycle is the WIDTH-th one.
    assign last_iter_s = (cnt_r == CNT_W'(WIDTH - 1));

    // State and iteration counter registers.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_r <= IDLE;
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
        end
    end

    // Next-state, counter update and strobe decode.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        load_s       = 1'b0;
        sh_s         = 1'b0;
        ad_s         = 1'b0;
        done_s       = 1'b0;
        busy_s       = 1'b0;

        case (state_r)
            IDLE: begin
                if (ctl.St) begin
                    state_next_s = LOAD;
                end else begin
                    state_next_s = IDLE;
                end
            end

            LOAD: begin
                load_s     = 1'b1;
                busy_s     = 1'b1;
                cnt_next_s = {CNT_W{1'b0}};
                if (abort_s) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = RUN;
                end
            end

            RUN: begin
                busy_s = 1'b1;
                // An add cycle is always followed by exactly one SHIFT cycle,
                // so the counter only advances on the shift of each iteration.
                if (ctl.M) begin
                    ad_s = 1'b1;
                end else begin
                    sh_s = 1'b1;
                end
                if (abort_s) begin
                    state_next_s = IDLE;
                    cnt_next_s   = {CNT_W{1'b0}};
                end else if (ctl.M) begin
                    state_next_s = SHIFT;
                end else if (last_iter_s) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = RUN;
                    cnt_next_s   = cnt_r + CNT_W'(1);
                end
            end

            SHIFT: begin
                sh_s   = 1'b1;
                busy_s = 1'b1;
                if (abort_s) begin
                    state_next_s = IDLE;
                    cnt_next_s   = {CNT_W{1'b0}};
                end else if (last_iter_s) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = RUN;
                    cnt_next_s   = cnt_r + CNT_W'(1);
                end
            end

            DONE: begin
                done_s = 1'b1;
                // Held St keeps the product presented; no retrigger until St drops.
                if (ctl.St) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = IDLE;
                end
            end

            default: begin
                state_next_s = IDLE;
                cnt_next_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    assign ctl.Load = load_s;
    assign ctl.Sh   = sh_s;
    assign ctl.Ad   = ad_s;
    assign ctl.Done = done_s;
    assign ctl.Busy = busy_s;

endmodule
